// File: rtl/character_display_controller.sv
// Sprite engine: sweeps the five moving characters as 5x5 bitmaps, one pixel per clock.
// Optional macro CDC_SCREEN_CLIP_EN suppresses plots that fall outside the 160x120 screen.
module character_display_controller #(
    parameter logic [2:0] PACMAN_COLOR = 3'b110,
    parameter logic [2:0] GHOST1_COLOR = 3'b100,
    parameter logic [2:0] GHOST2_COLOR = 3'b101,
    parameter logic [2:0] GHOST3_COLOR = 3'b011,
    parameter logic [2:0] GHOST4_COLOR = 3'b010
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       en,
    input  logic       pacman_orientation,
    output logic [2:0] character_type,
    input  logic [7:0] char_x,
    input  logic [7:0] char_y,
    output logic       vga_plot,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_color
);

    logic [2:0] col;
    logic [2:0] row;
    logic [2:0] char_cnt;
    logic [0:4] row_bits;
    logic [2:0] pixel_color;
    logic       pixel_on;
    logic [8:0] sum_x;
    logic [8:0] sum_y;

    assign character_type = char_cnt;
    assign sum_x = {1'b0, char_x} + {6'b0, col};
    assign sum_y = {1'b0, char_y} + {6'b0, row};

    // Bitmap row for the current character; index 0 of row_bits is the leftmost column.
    always_comb begin
        row_bits    = 5'b00000;
        pixel_color = 3'b000;
        case (char_cnt)
            3'd0: begin
                pixel_color = PACMAN_COLOR;
                if (pacman_orientation) begin
                    case (row)
                        3'd0: row_bits = 5'b01110;
                        3'd1: row_bits = 5'b01111;
                        3'd2: row_bits = 5'b00111;
                        3'd3: row_bits = 5'b01111;
                        3'd4: row_bits = 5'b01110;
                        default: row_bits = 5'b00000;
                    endcase
                end else begin
                    case (row)
                        3'd0: row_bits = 5'b01110;
                        3'd1: row_bits = 5'b11110;
                        3'd2: row_bits = 5'b11100;
                        3'd3: row_bits = 5'b11110;
                        3'd4: row_bits = 5'b01110;
                        default: row_bits = 5'b00000;
                    endcase
                end
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                case (char_cnt)
                    3'd1:    pixel_color = GHOST1_COLOR;
                    3'd2:    pixel_color = GHOST2_COLOR;
                    3'd3:    pixel_color = GHOST3_COLOR;
                    default: pixel_color = GHOST4_COLOR;
                endcase
                case (row)
                    3'd0: row_bits = 5'b01110;
                    3'd1: row_bits = 5'b11111;
                    3'd2: row_bits = 5'b10101;
                    3'd3: row_bits = 5'b11111;
                    3'd4: row_bits = 5'b10101;
                    default: row_bits = 5'b00000;
                endcase
            end
            default: begin
                row_bits    = 5'b00000;
                pixel_color = 3'b000;
            end
        endcase
    end

    always_comb begin
        pixel_on = 1'b0;
        if (col <= 3'd4) begin
            pixel_on = row_bits[col];
        end
`ifdef CDC_SCREEN_CLIP_EN
        if ((sum_x > 9'd159) || (sum_y > 9'd119)) begin
            pixel_on = 1'b0;
        end
`endif
    end

    // Column fastest, then row, then character; an illegal character index recovers to Pac-Man.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            col      <= 3'd0;
            row      <= 3'd0;
            char_cnt <= 3'd0;
        end else if (char_cnt > 3'd4) begin
            col      <= 3'd0;
            row      <= 3'd0;
            char_cnt <= 3'd0;
        end else if (en) begin
            if (col == 3'd4) begin
                col <= 3'd0;
                if (row == 3'd4) begin
                    row      <= 3'd0;
                    char_cnt <= (char_cnt == 3'd4) ? 3'd0 : char_cnt + 3'd1;
                end else begin
                    row <= row + 3'd1;
                end
            end else begin
                col <= col + 3'd1;
            end
        end
    end

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            vga_plot  <= 1'b0;
            vga_x     <= 8'd0;
            vga_y     <= 8'd0;
            vga_color <= 3'd0;
        end else if (en) begin
            vga_plot  <= pixel_on;
            vga_x     <= sum_x[7:0];
            vga_y     <= sum_y[7:0];
            vga_color <= pixel_color;
        end else begin
            vga_plot <= 1'b0;
        end
    end

endmodule

// File: tb/tb_character_display_controller.sv
// Directed self-checking bench for character_display_controller.
// The bench emulates the parent position mux driven by character_type.
module tb_character_display_controller;

    logic       clock_50 = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       pacman_orientation = 1'b0;
    logic [2:0] character_type;
    logic [7:0] char_x;
    logic [7:0] char_y;
    logic       vga_plot;
    logic [7:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_color;

    logic [7:0] pos_x [5];
    logic [7:0] pos_y [5];

    int assertions = 0;
    int failures = 0;

    character_display_controller dut (
        .clock_50(clock_50),
        .reset(reset),
        .en(en),
        .pacman_orientation(pacman_orientation),
        .character_type(character_type),
        .char_x(char_x),
        .char_y(char_y),
        .vga_plot(vga_plot),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_color(vga_color)
    );

    always #10 clock_50 = ~clock_50;

    always_comb begin
        char_x = 8'd0;
        char_y = 8'd0;
        case (character_type)
            3'd0: begin char_x = pos_x[0]; char_y = pos_y[0]; end
            3'd1: begin char_x = pos_x[1]; char_y = pos_y[1]; end
            3'd2: begin char_x = pos_x[2]; char_y = pos_y[2]; end
            3'd3: begin char_x = pos_x[3]; char_y = pos_y[3]; end
            3'd4: begin char_x = pos_x[4]; char_y = pos_y[4]; end
            default: begin char_x = 8'd0; char_y = 8'd0; end
        endcase
    end

    task automatic set_positions();
        pos_x[0] = 8'd10;  pos_y[0] = 8'd20;
        pos_x[1] = 8'd30;  pos_y[1] = 8'd40;
        pos_x[2] = 8'd60;  pos_y[2] = 8'd40;
        pos_x[3] = 8'd90;  pos_y[3] = 8'd40;
        pos_x[4] = 8'd120; pos_y[4] = 8'd40;
    endtask

    task automatic step();
        @(posedge clock_50);
        @(negedge clock_50);
    endtask

    task automatic do_reset();
        @(negedge clock_50);
        en = 1'b0;
        reset = 1'b0;
        @(negedge clock_50);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_positions();
        pacman_orientation = 1'b0;
        @(negedge clock_50);
        reset = 1'b0;
        #1;
        assertions++; if (vga_plot !== 1'b0) begin failures++; $display("[TB] FAIL reset_plot got %0b want 0", vga_plot); end
        assertions++; if (vga_x !== 8'd0) begin failures++; $display("[TB] FAIL reset_x got %0d want 0", vga_x); end
        assertions++; if (vga_y !== 8'd0) begin failures++; $display("[TB] FAIL reset_y got %0d want 0", vga_y); end
        assertions++; if (vga_color !== 3'd0) begin failures++; $display("[TB] FAIL reset_color got %0b want 000", vga_color); end
        assertions++; if (character_type !== 3'd0) begin failures++; $display("[TB] FAIL reset_ctype got %0d want 0", character_type); end
        @(negedge clock_50);
        reset = 1'b1;
        en = 1'b1;
        step();
        assertions++; if (vga_x !== 8'd10) begin failures++; $display("[TB] FAIL first_x got %0d want 10", vga_x); end
        assertions++; if (vga_y !== 8'd20) begin failures++; $display("[TB] FAIL first_y got %0d want 20", vga_y); end
        assertions++; if (vga_plot !== 1'b0) begin failures++; $display("[TB] FAIL first_plot got %0b want 0", vga_plot); end
        assertions++; if (vga_color !== 3'b110) begin failures++; $display("[TB] FAIL first_color got %0b want 110", vga_color); end
        assertions++; if (character_type !== 3'd0) begin failures++; $display("[TB] FAIL first_ctype got %0d want 0", character_type); end
        step();
        assertions++; if (vga_x !== 8'd11) begin failures++; $display("[TB] FAIL second_x got %0d want 11", vga_x); end
        assertions++; if (vga_plot !== 1'b1) begin failures++; $display("[TB] FAIL second_plot got %0b want 1", vga_plot); end
    endtask

    task automatic test_sweep();
        logic [2:0] exp_color [5];
        int         exp_count [5];
        int         plot_count [5];
        logic [2:0] exp_ct;
        logic [7:0] exp_x;
        logic [7:0] exp_y;
        int         ch;
        exp_color[0] = 3'b110; exp_color[1] = 3'b100; exp_color[2] = 3'b101;
        exp_color[3] = 3'b011; exp_color[4] = 3'b010;
        exp_count[0] = 17; exp_count[1] = 19; exp_count[2] = 19;
        exp_count[3] = 19; exp_count[4] = 19;
        for (int k = 0; k < 5; k++) plot_count[k] = 0;
        set_positions();
        pacman_orientation = 1'b0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 125; i++) begin
            ch = i / 25;
            exp_ct = 3'(ch);
            assertions++; if (character_type !== exp_ct) begin failures++; $display("[TB] FAIL sweep_ctype cycle %0d got %0d want %0d", i, character_type, exp_ct); end
            step();
            if (vga_plot === 1'b1) plot_count[ch]++;
            exp_x = pos_x[ch] + 8'((i % 25) % 5);
            exp_y = pos_y[ch] + 8'((i % 25) / 5);
            assertions++; if (vga_x !== exp_x || vga_y !== exp_y) begin failures++; $display("[TB] FAIL sweep_xy cycle %0d got (%0d,%0d) want (%0d,%0d)", i, vga_x, vga_y, exp_x, exp_y); end
            if (i % 25 == 0) begin
                assertions++; if (vga_color !== exp_color[ch]) begin failures++; $display("[TB] FAIL sweep_color char %0d got %0b want %0b", ch, vga_color, exp_color[ch]); end
            end
        end
        assertions++; if (character_type !== 3'd0) begin failures++; $display("[TB] FAIL sweep_wrap_ctype got %0d want 0", character_type); end
        for (int k = 0; k < 5; k++) begin
            assertions++; if (plot_count[k] != exp_count[k]) begin failures++; $display("[TB] FAIL sweep_plot_count char %0d got %0d want %0d", k, plot_count[k], exp_count[k]); end
        end
    endtask

    task automatic test_orientation();
        logic exp_left;
        logic exp_right;
        for (int o = 0; o < 2; o++) begin
            set_positions();
            pos_x[0] = 8'd50;
            pos_y[0] = 8'd50;
            pacman_orientation = o[0];
            exp_left  = (o == 1) ? 1'b0 : 1'b1;
            exp_right = (o == 1) ? 1'b1 : 1'b0;
            do_reset();
            en = 1'b1;
            for (int i = 0; i < 15; i++) begin
                step();
                if (i == 10) begin
                    assertions++; if (vga_x !== 8'd50 || vga_y !== 8'd52) begin failures++; $display("[TB] FAIL orient_xy_left got (%0d,%0d) want (50,52)", vga_x, vga_y); end
                    assertions++; if (vga_plot !== exp_left) begin failures++; $display("[TB] FAIL orient_plot_left orient %0d got %0b want %0b", o, vga_plot, exp_left); end
                end
                if (i == 14) begin
                    assertions++; if (vga_x !== 8'd54 || vga_y !== 8'd52) begin failures++; $display("[TB] FAIL orient_xy_right got (%0d,%0d) want (54,52)", vga_x, vga_y); end
                    assertions++; if (vga_plot !== exp_right) begin failures++; $display("[TB] FAIL orient_plot_right orient %0d got %0b want %0b", o, vga_plot, exp_right); end
                end
            end
        end
        pacman_orientation = 1'b0;
    endtask

    task automatic test_en_hold();
        set_positions();
        do_reset();
        en = 1'b1;
        repeat (66) step();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            assertions++; if (vga_plot !== 1'b0) begin failures++; $display("[TB] FAIL hold_plot cycle %0d got %0b want 0", i, vga_plot); end
            assertions++; if (character_type !== 3'd2) begin failures++; $display("[TB] FAIL hold_ctype cycle %0d got %0d want 2", i, character_type); end
            assertions++; if (vga_x !== 8'd60 || vga_y !== 8'd43) begin failures++; $display("[TB] FAIL hold_xy cycle %0d got (%0d,%0d) want (60,43)", i, vga_x, vga_y); end
        end
        en = 1'b1;
        step();
        assertions++; if (vga_x !== 8'd61 || vga_y !== 8'd43) begin failures++; $display("[TB] FAIL resume_xy got (%0d,%0d) want (61,43)", vga_x, vga_y); end
        assertions++; if (vga_plot !== 1'b1) begin failures++; $display("[TB] FAIL resume_plot got %0b want 1", vga_plot); end
        step();
        assertions++; if (vga_x !== 8'd62) begin failures++; $display("[TB] FAIL resume_next_x got %0d want 62", vga_x); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_x [5];
        logic       exp_plot [5];
        exp_x[0] = 8'd254; exp_x[1] = 8'd255; exp_x[2] = 8'd0; exp_x[3] = 8'd1; exp_x[4] = 8'd2;
        exp_plot[0] = 1'b0; exp_plot[1] = 1'b1; exp_plot[2] = 1'b1; exp_plot[3] = 1'b1; exp_plot[4] = 1'b0;
        set_positions();
        pos_x[4] = 8'd254;
        pos_y[4] = 8'd118;
        do_reset();
        en = 1'b1;
        repeat (100) step();
        for (int j = 0; j < 25; j++) begin
            step();
            if (j < 5) begin
                assertions++; if (vga_x !== exp_x[j] || vga_y !== 8'd118) begin failures++; $display("[TB] FAIL wrap_xy pixel %0d got (%0d,%0d) want (%0d,118)", j, vga_x, vga_y, exp_x[j]); end
`ifndef CDC_SCREEN_CLIP_EN
                assertions++; if (vga_plot !== exp_plot[j]) begin failures++; $display("[TB] FAIL wrap_plot pixel %0d got %0b want %0b", j, vga_plot, exp_plot[j]); end
`endif
            end
`ifdef CDC_SCREEN_CLIP_EN
            assertions++; if (vga_plot !== 1'b0) begin failures++; $display("[TB] FAIL clip_plot pixel %0d got %0b want 0", j, vga_plot); end
`endif
        end
    endtask

    task automatic test_async_reset();
        set_positions();
        do_reset();
        en = 1'b1;
        repeat (81) step();
        assertions++; if (character_type !== 3'd3) begin failures++; $display("[TB] FAIL areset_pre_ctype got %0d want 3", character_type); end
        assertions++; if (vga_plot !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_plot got %0b want 1", vga_plot); end
        #3;
        reset = 1'b0;
        #1;
        assertions++; if (vga_plot !== 1'b0) begin failures++; $display("[TB] FAIL areset_plot got %0b want 0", vga_plot); end
        assertions++; if (character_type !== 3'd0) begin failures++; $display("[TB] FAIL areset_ctype got %0d want 0", character_type); end
        assertions++; if (vga_x !== 8'd0) begin failures++; $display("[TB] FAIL areset_x got %0d want 0", vga_x); end
        @(negedge clock_50);
        reset = 1'b1;
        step();
        assertions++; if (vga_x !== 8'd10 || vga_y !== 8'd20) begin failures++; $display("[TB] FAIL areset_restart_xy got (%0d,%0d) want (10,20)", vga_x, vga_y); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_orientation();
        test_en_hold();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/character_display_controller.md
Name: character_display_controller

Overview:
- Draws the five moving characters (Pac-Man, ghosts 1–4) as 5x5-pixel sprites on the 160x120 VGA framebuffer, one pixel per clock.
- Selects which character it is drawing via the character_type output; the parent muxes that character's position onto char_x/char_y in the same cycle.
- Runs continuously. The parent display controller time-slices its pixel stream with the map display controller's stream.

Parameters:
- PACMAN_COLOR, 3'b110, Pac-Man colour (yellow)
- GHOST1_COLOR, 3'b100, ghost 1 colour (red)
- GHOST2_COLOR, 3'b101, ghost 2 colour (magenta)
- GHOST3_COLOR, 3'b011, ghost 3 colour (cyan)
- GHOST4_COLOR, 3'b010, ghost 4 colour (green)

Ports:
- clock_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  1 = advance/draw; 0 = freeze counters, no plotting
- pacman_orientation  in  1  0 = Pac-Man faces right, 1 = faces left
- character_type  out  3  character being drawn: 0 = Pac-Man, 1–4 = ghost 1–4; combinational from internal counter
- char_x  in  8  top-left x of selected character (parent mux of character_type)
- char_y  in  8  top-left y of selected character
- vga_plot  out  1  registered write strobe
- vga_x  out  8  registered pixel x
- vga_y  out  8  registered pixel y
- vga_color  out  3  registered pixel colour (RGB)

Behaviour:
- State:
  - col counter 0..4
  - row counter 0..4
  - char counter 0..4, driven directly on character_type
- Reset (reset=0, async): col=row=char=0; vga_plot=0, vga_x=0, vga_y=0, vga_color=0.
- Each clock with en=1, counters advance:
  - col increments.
  - col 4→0 increments row.
  - row 4→0 (with col 4) increments char.
  - char 4→0 wraps.
  - Full sweep = 125 cycles: 25 per character, row-major, column fastest.
- Registered pixel outputs, sampled when en=1 (latency 1 cycle from counter/char_x/char_y to outputs):
  - vga_x <= char_x + col
  - vga_y <= char_y + row
  - vga_color <= colour of char
  - vga_plot <= bitmap bit (char, row, col)
- Arithmetic is 8-bit modulo 256; no saturation.
- en=0: counters hold; vga_plot <= 0; vga_x, vga_y, vga_color hold.
- Bitmaps: rows top to bottom, bit string left = col 0; 1 = plot, 0 = transparent (vga_plot=0).
  - Pac-Man right: 01110, 11110, 11100, 11110, 01110
  - Pac-Man left: 01110, 01111, 00111, 01111, 01110
  - Ghost (all four): 01110, 11111, 10101, 11111, 10101
- pacman_orientation is sampled per pixel. A change mid-sprite takes effect on the next pixel.
- Illegal char values 5–7 are unreachable. If one is forced, plot nothing and load char=0 next cycle.
- Reset asserted mid-sweep: immediate return to reset state. Drawing restarts at Pac-Man pixel (0,0) on the first enabled clock after release.

Optional Feature:
- Macro CDC_SCREEN_CLIP_EN.
  - Defined: vga_plot is forced 0 for any pixel where char_x+col (9-bit true sum) > 159 or char_y+row (9-bit) > 119. No wrapped or off-screen writes.
  - Undefined: no clipping; coordinates wrap modulo 256 as above.

Test Plan:
- Reset and first pixel:
  - Stimulus: reset=0 then release, en=1, char 0 at (10,20), orientation 0.
  - Required: character_type=0; the cycle after the first enabled edge gives vga_x=10, vga_y=20, vga_plot=0 (bitmap 0), colour 110.
  - Next cycle gives vga_x=11, vga_plot=1.
- Full sweep ordering:
  - Stimulus: en=1 for 125 cycles.
  - Required: character_type is 0 for cycles 0–24, 1 for 25–49, …, 4 for 100–124, then 0 again at cycle 125.
  - Plot count per character: Pac-Man 17, each ghost 19.
- Orientation:
  - Stimulus: pacman_orientation=1, Pac-Man at (50,50).
  - Required: pixel (50,52) has vga_plot=0 and (54,52) has vga_plot=1; the reverse with orientation=0.
- en hold:
  - Stimulus: deassert en at character_type=2, row 3, col 1 for 10 cycles.
  - Required: vga_plot=0 throughout, character_type stays 2, and resume continues at row 3 col 1 with no pixel skipped.
- Wrap/clip:
  - Stimulus: ghost 4 at (254,118).
  - Without macro: vga_x sequence 254, 255, 0, 1, 2.
  - With CDC_SCREEN_CLIP_EN: all ghost-4 plots suppressed.
- Async reset mid-sweep:
  - Stimulus: assert reset between clock edges at character_type=3.
  - Required: vga_plot=0 and character_type=0 immediately, without waiting for a clock edge.
